// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

   localparam int REFRAC_W  = 4;
   localparam int MAX_CNT_W = 32;

   // Select/address width for n neurons, never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [MAX_CNT_W-1:0] sat_add1(input logic [MAX_CNT_W-1:0] v,
                                                     input int unsigned w);
      logic [MAX_CNT_W-1:0] max_v;
      max_v = (w >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << w) - MAX_CNT_W'(1));
      return (v >= max_v) ? max_v : v + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/lif_array_if.sv
// Step/config/readout bus between a controller and the neuron array.
interface lif_array_if
   import lif_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int IN_W      = 8,
   parameter int STATE_W   = 8,
   parameter int CNT_W     = 8
);
   localparam int ADDR_W = addr_w(N_NEURONS);

   logic                 en;
   logic [IN_W-1:0]      current;
   logic                 cfg_we;
   logic [ADDR_W-1:0]    cfg_addr;
   logic [IN_W-1:0]      cfg_bias;
   logic                 cnt_clr;
   logic [ADDR_W-1:0]    sel;
   logic [N_NEURONS-1:0] spike;
   logic [STATE_W-1:0]   state_out;
   logic [CNT_W-1:0]     count_out;

   modport master (
      output en, current, cfg_we, cfg_addr, cfg_bias, cnt_clr, sel,
      input  spike, state_out, count_out
   );

   modport slave (
      input  en, current, cfg_we, cfg_addr, cfg_bias, cnt_clr, sel,
      output spike, state_out, count_out
   );
endinterface

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron with bias, refractory timer and spike counter.
module lif_cell
   import lif_pkg::*;
#(
   parameter int IN_W       = 8,
   parameter int STATE_W    = 8,
   parameter int THRESHOLD  = 200,
   parameter int LEAK_SHIFT = 1,
   parameter int REFRAC     = 2,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_en,
   input  logic [IN_W-1:0]    i_current,
   input  logic               i_bias_we,
   input  logic [IN_W-1:0]    i_bias,
   input  logic               i_cnt_clr,
   output logic               o_spike,
   output logic [STATE_W-1:0] o_state,
   output logic [CNT_W-1:0]   o_count
);
   // Two guard bits keep current + bias + leaked state from wrapping.
   localparam int SUM_W = ((IN_W > STATE_W) ? IN_W : STATE_W) + 2;

   logic [STATE_W-1:0]  r_state;
   logic [IN_W-1:0]     r_bias;
   logic [REFRAC_W-1:0] r_refrac;
   logic [CNT_W-1:0]    r_count;
   logic                r_spike;

   logic [SUM_W-1:0]    w_sum;
   logic                w_fire;

   assign w_sum  = SUM_W'(i_current) + SUM_W'(r_bias) + SUM_W'(r_state >> LEAK_SHIFT);
   assign w_fire = i_en && (r_refrac == '0) && (w_sum >= SUM_W'(THRESHOLD));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= '0;
         r_bias   <= '0;
         r_refrac <= '0;
         r_count  <= '0;
         r_spike  <= 1'b0;
      end else begin
         r_spike <= w_fire;
         if (i_bias_we)
            r_bias <= i_bias;
         if (i_en) begin
            if (r_refrac != '0) begin
               r_state  <= '0;
               r_refrac <= r_refrac - REFRAC_W'(1);
            end else if (w_fire) begin
               r_state  <= '0;
               r_refrac <= REFRAC_W'(REFRAC);
            end else begin
               r_state  <= STATE_W'(w_sum);
            end
         end
         // Clear wins over an increment landing in the same cycle.
         if (i_cnt_clr)
            r_count <= '0;
         else if (w_fire)
            r_count <= CNT_W'(sat_add1(MAX_CNT_W'(r_count), CNT_W));
      end
   end

   assign o_spike = r_spike;
   assign o_state = r_state;
   assign o_count = r_count;
endmodule

// File: rtl/lif_array.sv
// Array of LIF neurons on one shared current bus, with bias write decode and readout mux.
module lif_array
   import lif_pkg::*;
#(
   parameter int N_NEURONS  = 4,
   parameter int IN_W       = 8,
   parameter int STATE_W    = 8,
   parameter int THRESHOLD  = 200,
   parameter int LEAK_SHIFT = 1,
   parameter int REFRAC     = 2,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   lif_array_if.slave bus
);
   localparam int ADDR_W = addr_w(N_NEURONS);

   logic [N_NEURONS-1:0] w_spike;
   logic [N_NEURONS-1:0] w_we;
   logic [STATE_W-1:0]   w_state [N_NEURONS];
   logic [CNT_W-1:0]     w_count [N_NEURONS];
   logic [STATE_W-1:0]   w_rd_state;
   logic [CNT_W-1:0]     w_rd_count;

   for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_cell
      // Addresses at or beyond N_NEURONS match no cell, so such writes drop.
      assign w_we[gi] = bus.cfg_we && (bus.cfg_addr == ADDR_W'(gi));

      lif_cell #(
         .IN_W       (IN_W),
         .STATE_W    (STATE_W),
         .THRESHOLD  (THRESHOLD),
         .LEAK_SHIFT (LEAK_SHIFT),
         .REFRAC     (REFRAC),
         .CNT_W      (CNT_W)
      ) u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_en       (bus.en),
         .i_current  (bus.current),
         .i_bias_we  (w_we[gi]),
         .i_bias     (bus.cfg_bias),
         .i_cnt_clr  (bus.cnt_clr),
         .o_spike    (w_spike[gi]),
         .o_state    (w_state[gi]),
         .o_count    (w_count[gi])
      );
   end

   always_comb begin
      w_rd_state = '0;
      w_rd_count = '0;
      for (int i = 0; i < N_NEURONS; i++) begin
         if (bus.sel == ADDR_W'(i)) begin
            w_rd_state = w_state[i];
            w_rd_count = w_count[i];
         end
      end
   end

   assign bus.spike     = w_spike;
   assign bus.state_out = w_rd_state;
   assign bus.count_out = w_rd_count;
endmodule

// File: doc/lif_array.md
# lif_array

Parametrised array of N leaky integrate-and-fire neurons sharing one input current bus. This is the next-generation neuron core for the Tiny Tapeout top level. Each neuron adds:
- a runtime-programmable per-neuron bias (replacing fixed "noise" offsets);
- a configurable leak shift and refractory period;
- a global step enable;
- a saturating per-neuron spike counter.

The top level routes `spike` to `uio_out` and the selected neuron's state or count to `uo_out`.

## Interface
Parameters:
- `N_NEURONS`, 4, number of neurons (2..16)
- `IN_W`, 8, width of input current and bias
- `STATE_W`, 8, membrane state width
- `THRESHOLD`, 200, firing threshold; legal range 1..2^STATE_W-1
- `LEAK_SHIFT`, 1, leak is `state >> LEAK_SHIFT` retained per step (1..STATE_W-1)
- `REFRAC`, 2, refractory steps after a spike (0..15)
- `CNT_W`, 8, spike counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `en`  in  1  step strobe; neurons advance only on cycles with en=1
- `current`  in  IN_W  shared input current, unsigned
- `cfg_we`  in  1  bias write strobe
- `cfg_addr`  in  clog2(N)  bias write target
- `cfg_bias`  in  IN_W  bias value, unsigned
- `cnt_clr`  in  1  clear all spike counters
- `sel`  in  clog2(N)  readout select
- `spike`  out  N  registered spike pulses, bit i = neuron i
- `state_out`  out  STATE_W  membrane state of neuron `sel`
- `count_out`  out  CNT_W  spike count of neuron `sel`

## Operation
- Per neuron i, registers: `state` (STATE_W), `bias` (IN_W), `refrac_cnt` (4 b), `count` (CNT_W), `spike_q`.
- On a cycle with en=1 and `refrac_cnt`=0:
  - compute `sum = current + bias_i + (state >> LEAK_SHIFT)` at max(IN_W, STATE_W)+2 bits, with no overflow;
  - if `sum >= THRESHOLD`: `state <= 0`, `spike_q <= 1`, `refrac_cnt <= REFRAC`, and `count` increments (saturating at all-ones);
  - otherwise `state <= sum` (which is always < THRESHOLD, so it fits STATE_W) and `spike_q <= 0`.
- On a cycle with en=1 and `refrac_cnt`>0: `state` held at 0, `refrac_cnt` decrements, `spike_q <= 0`, and `current` is ignored.
- On a cycle with en=0: `state`, `refrac_cnt` and `count` hold, and `spike_q <= 0`. A spike is therefore always a single-cycle pulse.
- Bias write: when cfg_we=1 and `cfg_addr < N_NEURONS`, `bias[cfg_addr] <= cfg_bias`.
  - Out-of-range addresses are ignored.
  - A write in the same cycle as en=1 does not affect that step; the step uses the old bias.
- `cnt_clr`=1 zeroes all counters. It has priority over a same-cycle increment, so the result is 0.
- Readout: `state_out`/`count_out` are a combinational mux of registers indexed by `sel`. If `sel >= N_NEURONS`, both outputs are 0.
- Reset (rst_n=0 at a clock edge): all `state`, `bias`, `refrac_cnt`, `count`, `spike_q` are cleared to 0.
  - Outputs after reset: `spike`=0, `state_out`=0, `count_out`=0.
  - Reset overrides en, cfg_we and cnt_clr, and aborts any refractory period.

## Timing
- One step per en cycle, with no stall. Every neuron updates in parallel in the same cycle.
- Spike latency: `spike[i]` is high in the cycle after the en edge whose `sum` crossed threshold. In that same cycle `state_out` reads 0 and `count_out` reads the incremented value.
- Bias write latency: 1 cycle; the new bias is used from the next en cycle onward.
- With REFRAC=R and a sustained supra-threshold input, the minimum spike period is R+1 en cycles.

## Structure
- Package `lif_pkg`: `ADDR_W` helper (clog2 of N, minimum 1), refractory counter width constant, and a saturating-add function used for the counters.
- Sub-module `lif_cell`: one neuron holding state, bias register, refractory counter, spike counter and spike register. Its parameters are passed through from the array.
- `lif_array`: generate loop over the cells, bias address decode, readout mux.

## Test plan
All scenarios use default parameters.
- Reset: hold rst_n=0 with en=1, current=255, then release. Expected: all outputs 0 for the whole of reset; no spike in the first cycle after release.
- Sub-threshold convergence: bias0=0, current=100, en=1 continuously, sel=0. Expected: `state_out` = 100, 150, 175, 187, 193, 196, 198, 199, 199…; no spike ever.
- Threshold crossing with bias: bias1=1, current=100, sel=1. Expected: `state_out` = 101, 151, 176, 189, 195, 198, then `spike[1]`=1 with state 0 on the 7th step; 2 refractory steps at state 0; then integration restarts at 101.
- Refractory period and gating: current=200, all biases 0. Expected: every neuron spikes on steps 1, 4, 7 (period 3). With en toggling 1,0,1,0, spikes occur only after en cycles and state holds on en=0 cycles.
- Counters: 260 forced spikes on neuron 2. Expected: `count_out` saturates at 255. Asserting cnt_clr in the same cycle as a spike gives 0.
- Config edge cases:
  - write with `cfg_addr`=3 concurrent with en=1: that step uses the old bias;
  - out-of-range `sel` or `cfg_addr` (for N=3 builds): writes are ignored and readout is 0.
